// File: rtl/ibex_pkg.sv
// Shared types for the writeback queue slice: instruction class and queue entry layout.
package ibex_pkg;

  typedef enum logic [1:0] {
    WB_INSTR_LOAD  = 2'd0,
    WB_INSTR_STORE = 2'd1,
    WB_INSTR_OTHER = 2'd2
  } wb_instr_type_e;

  typedef struct packed {
    wb_instr_type_e instr_type;
    logic           we;
    logic [4:0]     waddr;
    logic [31:0]    wdata;
    logic [31:0]    pc;
    logic           compressed;
    logic           count;
  } wb_entry_t;

  function automatic logic is_lsu_type(input wb_instr_type_e t);
    return (t != WB_INSTR_OTHER);
  endfunction

endpackage

// File: rtl/ibex_wb_hazard_lookup.sv
// Youngest-match search over the writeback queue for one register operand.
// An entry "writes" the operand if it has an ID result or is a load.
module ibex_wb_hazard_lookup #(
  parameter int unsigned Depth = 2,
  parameter int unsigned PtrW  = 1
) (
  input  logic [Depth-1:0]       valid,
  input  logic [Depth-1:0]       writes_rf,
  input  logic [Depth-1:0]       is_load,
  input  logic [Depth-1:0][4:0]  waddr,
  input  logic [Depth-1:0][31:0] wdata,
  input  logic [PtrW-1:0]        wr_ptr,
  input  logic [4:0]             raddr,
  output logic                   hazard,
  output logic                   fwd,
  output logic [31:0]            fwd_data
);

  int unsigned wp_s;
  int unsigned age_s;
  int unsigned best_age_s;
  logic        take_s;
  logic        hit_s;
  logic        load_s;
  logic [31:0] data_s;

  assign wp_s = 32'(wr_ptr);

  // Age 1 is the slot just behind wr_ptr; keep the matching entry with the smallest age.
  always_comb begin
    age_s      = 32'd0;
    best_age_s = Depth + 32'd1;
    take_s     = 1'b0;
    hit_s      = 1'b0;
    load_s     = 1'b0;
    data_s     = 32'h0;
    for (int unsigned i = 0; i < Depth; i++) begin
      age_s      = (wp_s > i) ? (wp_s - i) : (wp_s + Depth - i);
      take_s     = valid[i] & writes_rf[i] & (raddr != 5'd0) & (waddr[i] == raddr) &
                   (age_s < best_age_s);
      best_age_s = take_s ? age_s : best_age_s;
      hit_s      = hit_s | take_s;
      load_s     = take_s ? is_load[i] : load_s;
      data_s     = take_s ? wdata[i] : data_s;
    end
  end

  assign hazard   = hit_s & load_s;
  assign fwd      = hit_s & ~load_s;
  assign fwd_data = data_s;

endmodule

// File: rtl/ibex_wb_queue_assert.sv
// Protocol checks on the writeback queue's inputs.
module ibex_wb_queue_assert (
  input logic clk_i,
  input logic rst_ni,
  input logic en_wb,
  input logic ready_wb,
  input logic head_we,
  input logic rf_we_lsu,
  input logic lsu_resp_valid,
  input logic head_is_lsu
);

  a_push_needs_ready: assert property (@(posedge clk_i) disable iff (!rst_ni)
    en_wb |-> ready_wb);

  a_single_rf_writer: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(head_we && rf_we_lsu));

  a_resp_needs_lsu_head: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lsu_resp_valid |-> head_is_lsu);

endmodule

// File: rtl/ibex_wb_queue.sv
// In-order multi-entry writeback queue between ID/EX and the register file.
// Retires at most one entry per cycle and reports per-operand hazards/forwarding.
module ibex_wb_queue
  import ibex_pkg::*;
#(
  parameter int unsigned Depth    = 2,
  parameter bit          ResetAll = 1'b0
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           en_wb_i,
  input  wb_instr_type_e instr_type_wb_i,
  input  logic [31:0]    pc_id_i,
  input  logic           instr_is_compressed_id_i,
  input  logic           instr_perf_count_id_i,
  input  logic [4:0]     rf_waddr_id_i,
  input  logic [31:0]    rf_wdata_id_i,
  input  logic           rf_we_id_i,
  input  logic [4:0]     rf_raddr_a_i,
  input  logic [4:0]     rf_raddr_b_i,
  input  logic [31:0]    rf_wdata_lsu_i,
  input  logic           rf_we_lsu_i,
  input  logic           lsu_resp_valid_i,
  input  logic           lsu_resp_err_i,
  output logic           ready_wb_o,
  output logic           outstanding_load_wb_o,
  output logic           outstanding_store_wb_o,
  output logic [31:0]    pc_wb_o,
  output logic           rf_hazard_a_o,
  output logic           rf_hazard_b_o,
  output logic           rf_fwd_a_o,
  output logic           rf_fwd_b_o,
  output logic [31:0]    rf_fwd_data_a_o,
  output logic [31:0]    rf_fwd_data_b_o,
  output logic [4:0]     rf_waddr_wb_o,
  output logic [31:0]    rf_wdata_wb_o,
  output logic           rf_we_wb_o,
  output logic           perf_instr_ret_wb_o,
  output logic           perf_instr_ret_compressed_wb_o,
  output logic           instr_done_wb_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  wb_entry_t              entries_r [Depth];
  logic [Depth-1:0]       valid_r;
  logic [PtrW-1:0]        wr_ptr_r;
  logic [PtrW-1:0]        rd_ptr_r;
  logic [CntW-1:0]        count_r;

  wb_entry_t              head_s;
  wb_entry_t              new_entry_s;
  logic                   valid_head_s;
  logic                   head_we_s;
  logic                   head_done_s;
  logic                   push_s;
  logic [Depth-1:0]       writes_rf_s;
  logic [Depth-1:0]       is_load_s;
  logic [Depth-1:0]       is_store_s;
  logic [Depth-1:0][4:0]  waddr_s;
  logic [Depth-1:0][31:0] wdata_s;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign head_s       = entries_r[rd_ptr_r];
  assign valid_head_s = valid_r[rd_ptr_r];
  assign head_we_s    = valid_head_s & head_s.we;
  assign head_done_s  = valid_head_s &
                        ((head_s.instr_type == WB_INSTR_OTHER) | lsu_resp_valid_i);
  // A full queue still accepts when the head retires in the same cycle.
  assign ready_wb_o   = (count_r != CntW'(Depth)) | head_done_s;
  assign push_s       = en_wb_i & ready_wb_o;

  assign new_entry_s = '{
    instr_type: instr_type_wb_i,
    we:         rf_we_id_i,
    waddr:      rf_waddr_id_i,
    wdata:      rf_wdata_id_i,
    pc:         pc_id_i,
    compressed: instr_is_compressed_id_i,
    count:      instr_perf_count_id_i
  };

  // Valid bits, pointers and occupancy; a same-slot push overrides the pop clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_r  <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (head_done_s) begin
        valid_r[rd_ptr_r] <= 1'b0;
        rd_ptr_r          <= next_ptr(rd_ptr_r);
      end
      if (push_s) begin
        valid_r[wr_ptr_r] <= 1'b1;
        wr_ptr_r          <= next_ptr(wr_ptr_r);
      end
      count_r <= count_r + CntW'(push_s) - CntW'(head_done_s);
    end
  end

  if (ResetAll) begin : g_payload_rst
    // Payload storage, cleared on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int unsigned i = 0; i < Depth; i++) begin
          entries_r[i] <= '0;
        end
      end else if (push_s) begin
        entries_r[wr_ptr_r] <= new_entry_s;
      end
    end
  end else begin : g_payload_norst
    // Payload storage, qualified by valid bits only.
    always_ff @(posedge clk_i) begin
      if (push_s) begin
        entries_r[wr_ptr_r] <= new_entry_s;
      end
    end
  end

  // Per-entry status vectors, gated by valid.
  always_comb begin
    writes_rf_s = '0;
    is_load_s   = '0;
    is_store_s  = '0;
    waddr_s     = '0;
    wdata_s     = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      is_load_s[i]   = valid_r[i] & (entries_r[i].instr_type == WB_INSTR_LOAD);
      is_store_s[i]  = valid_r[i] & (entries_r[i].instr_type == WB_INSTR_STORE);
      writes_rf_s[i] = valid_r[i] &
                       (entries_r[i].we | (entries_r[i].instr_type == WB_INSTR_LOAD));
      waddr_s[i]     = entries_r[i].waddr;
      wdata_s[i]     = entries_r[i].wdata;
    end
  end

  assign outstanding_load_wb_o  = |is_load_s;
  assign outstanding_store_wb_o = |is_store_s;
  assign pc_wb_o                = head_s.pc;

  assign rf_waddr_wb_o = head_s.waddr;
  assign rf_we_wb_o    = head_we_s ? 1'b1 : rf_we_lsu_i;
  assign rf_wdata_wb_o = head_we_s ? head_s.wdata : rf_wdata_lsu_i;

  assign instr_done_wb_o     = head_done_s;
  assign perf_instr_ret_wb_o = head_done_s & head_s.count &
                               ~(lsu_resp_valid_i & lsu_resp_err_i);
  assign perf_instr_ret_compressed_wb_o = perf_instr_ret_wb_o & head_s.compressed;

  ibex_wb_hazard_lookup #(.Depth(Depth), .PtrW(PtrW)) u_lookup_a (
    .valid     (valid_r),
    .writes_rf (writes_rf_s),
    .is_load   (is_load_s),
    .waddr     (waddr_s),
    .wdata     (wdata_s),
    .wr_ptr    (wr_ptr_r),
    .raddr     (rf_raddr_a_i),
    .hazard    (rf_hazard_a_o),
    .fwd       (rf_fwd_a_o),
    .fwd_data  (rf_fwd_data_a_o)
  );

  ibex_wb_hazard_lookup #(.Depth(Depth), .PtrW(PtrW)) u_lookup_b (
    .valid     (valid_r),
    .writes_rf (writes_rf_s),
    .is_load   (is_load_s),
    .waddr     (waddr_s),
    .wdata     (wdata_s),
    .wr_ptr    (wr_ptr_r),
    .raddr     (rf_raddr_b_i),
    .hazard    (rf_hazard_b_o),
    .fwd       (rf_fwd_b_o),
    .fwd_data  (rf_fwd_data_b_o)
  );

  ibex_wb_queue_assert u_assert (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .en_wb          (en_wb_i),
    .ready_wb       (ready_wb_o),
    .head_we        (head_we_s),
    .rf_we_lsu      (rf_we_lsu_i),
    .lsu_resp_valid (lsu_resp_valid_i),
    .head_is_lsu    (valid_head_s & is_lsu_type(head_s.instr_type))
  );

endmodule

// File: tb/tb_ibex_wb_queue.sv
// Scoreboard bench for ibex_wb_queue at Depth 2 and Depth 3 against a queue-based model.
module tb_ibex_wb_queue;
  import ibex_pkg::*;

  typedef struct {
    wb_instr_type_e typ;
    logic [31:0]    pc;
    logic [4:0]     waddr;
    logic [31:0]    wdata;
    logic           we;
    logic           comp;
    logic           perf;
    logic           err;
    logic [31:0]    ldata;
  } rec_t;

  logic clk;
  int   errors = 0;
  int   checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(int d, string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL d%0d %s: got %0h, expected %0h", d, name, act, exp);
    end
  endfunction

  function automatic rec_t mk(wb_instr_type_e t, logic [4:0] a, logic [31:0] d, logic we,
                              logic err);
    rec_t r;
    r.typ   = t;
    r.pc    = $urandom & 32'hFFFF_FFFE;
    r.waddr = a;
    r.wdata = d;
    r.we    = we;
    r.comp  = 1'($urandom_range(0, 1));
    r.perf  = 1'b1;
    r.err   = err;
    r.ldata = $urandom;
    return r;
  endfunction

  function automatic rec_t rand_rec();
    rec_t r;
    int   t;
    t       = $urandom_range(0, 2);
    r.typ   = (t == 0) ? WB_INSTR_LOAD : ((t == 1) ? WB_INSTR_STORE : WB_INSTR_OTHER);
    r.pc    = $urandom & 32'hFFFF_FFFE;
    r.waddr = 5'($urandom_range(0, 7));
    r.wdata = $urandom;
    r.we    = (r.typ == WB_INSTR_OTHER) && ($urandom_range(0, 3) != 0);
    r.comp  = 1'($urandom_range(0, 1));
    r.perf  = 1'($urandom_range(0, 1));
    r.err   = (r.typ != WB_INSTR_OTHER) && ($urandom_range(0, 4) == 0);
    r.ldata = $urandom;
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_d
    localparam int unsigned D = (g == 0) ? 2 : 3;

    logic           rst_n, en, comp, perf, we_id, lsu_we, lsu_valid, lsu_err;
    wb_instr_type_e typ;
    logic [31:0]    pc, wdata, lsu_wdata;
    logic [4:0]     waddr, ra, rb;
    logic           ready, out_ld, out_st, hz_a, hz_b, fw_a, fw_b, we_wb, ret, ret_c, done;
    logic [31:0]    pc_wb, fd_a, fd_b, wdata_wb;
    logic [4:0]     waddr_wb;
    rec_t           model_q[$];
    rec_t           exp_q[$];
    rec_t           idle;
    bit             fin = 1'b0;

    ibex_wb_queue #(.Depth(D), .ResetAll(g == 1)) u_dut (
      .clk_i                          (clk),
      .rst_ni                         (rst_n),
      .en_wb_i                        (en),
      .instr_type_wb_i                (typ),
      .pc_id_i                        (pc),
      .instr_is_compressed_id_i       (comp),
      .instr_perf_count_id_i          (perf),
      .rf_waddr_id_i                  (waddr),
      .rf_wdata_id_i                  (wdata),
      .rf_we_id_i                     (we_id),
      .rf_raddr_a_i                   (ra),
      .rf_raddr_b_i                   (rb),
      .rf_wdata_lsu_i                 (lsu_wdata),
      .rf_we_lsu_i                    (lsu_we),
      .lsu_resp_valid_i               (lsu_valid),
      .lsu_resp_err_i                 (lsu_err),
      .ready_wb_o                     (ready),
      .outstanding_load_wb_o          (out_ld),
      .outstanding_store_wb_o         (out_st),
      .pc_wb_o                        (pc_wb),
      .rf_hazard_a_o                  (hz_a),
      .rf_hazard_b_o                  (hz_b),
      .rf_fwd_a_o                     (fw_a),
      .rf_fwd_b_o                     (fw_b),
      .rf_fwd_data_a_o                (fd_a),
      .rf_fwd_data_b_o                (fd_b),
      .rf_waddr_wb_o                  (waddr_wb),
      .rf_wdata_wb_o                  (wdata_wb),
      .rf_we_wb_o                     (we_wb),
      .perf_instr_ret_wb_o            (ret),
      .perf_instr_ret_compressed_wb_o (ret_c),
      .instr_done_wb_o                (done)
    );

    // Youngest in-flight instruction that writes the register (by result or as a load).
    function automatic void lookup(input logic [4:0] a, output logic hz, output logic fw,
                                   output logic [31:0] fd);
      hz = 1'b0; fw = 1'b0; fd = 32'h0;
      if (a != 5'd0) begin
        for (int i = model_q.size() - 1; i >= 0; i--) begin
          if (model_q[i].waddr == a && (model_q[i].we || model_q[i].typ == WB_INSTR_LOAD)) begin
            hz = (model_q[i].typ == WB_INSTR_LOAD);
            fw = !hz;
            fd = model_q[i].wdata;
            break;
          end
        end
      end
    endfunction

    task automatic step(input bit push, input rec_t r, input bit resp, input logic [4:0] a,
                        input logic [4:0] b);
      bit          head_lsu, hd, xr, ld, st;
      logic        h, f;
      logic [31:0] fdat;
      @(negedge clk);
      head_lsu  = (model_q.size() > 0) && (model_q[0].typ != WB_INSTR_OTHER);
      lsu_valid = resp && head_lsu;
      lsu_err   = lsu_valid && model_q[0].err;
      lsu_we    = lsu_valid && (model_q[0].typ == WB_INSTR_LOAD) && !model_q[0].err;
      lsu_wdata = lsu_valid ? model_q[0].ldata : $urandom;
      hd        = (model_q.size() > 0) && ((model_q[0].typ == WB_INSTR_OTHER) || lsu_valid);
      xr        = (model_q.size() < D) || hd;
      ld = 1'b0; st = 1'b0;
      foreach (model_q[i]) begin
        ld = ld || (model_q[i].typ == WB_INSTR_LOAD);
        st = st || (model_q[i].typ == WB_INSTR_STORE);
      end
      en = push && xr;
      typ = r.typ; pc = r.pc; comp = r.comp; perf = r.perf;
      waddr = r.waddr; wdata = r.wdata; we_id = r.we;
      ra = a; rb = b;
      if (en) exp_q.push_back(r);
      #1;
      chk(D, "ready", ready, xr);
      chk(D, "done", done, hd);
      chk(D, "out_load", out_ld, ld);
      chk(D, "out_store", out_st, st);
      lookup(a, h, f, fdat);
      chk(D, "hazard_a", hz_a, h);
      chk(D, "fwd_a", fw_a, f);
      if (f) chk(D, "fwd_data_a", fd_a, fdat);
      lookup(b, h, f, fdat);
      chk(D, "hazard_b", hz_b, h);
      chk(D, "fwd_b", fw_b, f);
      if (f) chk(D, "fwd_data_b", fd_b, fdat);
      @(posedge clk);
      if (hd) void'(model_q.pop_front());
      if (en) model_q.push_back(r);
    endtask

    task automatic drain();
      for (int n = 0; n < 4 * D + 4 && model_q.size() > 0; n++) begin
        step(1'b0, idle, 1'b1, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end
    endtask

    // Retire monitor: pops the expected record whenever the queue signals a retirement.
    initial begin
      rec_t        e;
      logic        xwe, xperf;
      logic [31:0] xd;
      forever begin
        @(negedge clk);
        #2;
        if (rst_n === 1'b1 && done === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL d%0d retire: got unexpected retire, expected none", D);
          end else begin
            e     = exp_q.pop_front();
            xwe   = (e.typ == WB_INSTR_OTHER) ? e.we : ((e.typ == WB_INSTR_LOAD) && !e.err);
            xd    = (e.typ == WB_INSTR_OTHER) ? e.wdata : e.ldata;
            xperf = e.perf && !((e.typ != WB_INSTR_OTHER) && e.err);
            chk(D, "ret_pc", pc_wb, e.pc);
            chk(D, "ret_rf_we", we_wb, xwe);
            if (xwe) begin
              chk(D, "ret_rf_waddr", waddr_wb, e.waddr);
              chk(D, "ret_rf_wdata", wdata_wb, xd);
            end
            chk(D, "ret_perf", ret, xperf);
            chk(D, "ret_perf_c", ret_c, xperf && e.comp);
          end
        end
      end
    end

    // Stimulus: directed scenarios, random traffic, then reset mid-operation.
    initial begin
      idle = mk(WB_INSTR_OTHER, 5'd0, 32'h0, 1'b0, 1'b0);
      rst_n = 1'b0; en = 1'b0; lsu_valid = 1'b0; lsu_err = 1'b0; lsu_we = 1'b1;
      lsu_wdata = 32'h0; typ = WB_INSTR_OTHER; pc = 32'h0; comp = 1'b0; perf = 1'b0;
      waddr = 5'd0; wdata = 32'h0; we_id = 1'b0; ra = 5'd5; rb = 5'd7;
      repeat (2) @(negedge clk);
      #1;
      chk(D, "rst_ready", ready, 32'd1);
      chk(D, "rst_out_load", out_ld, 32'd0);
      chk(D, "rst_out_store", out_st, 32'd0);
      chk(D, "rst_hazard_a", hz_a, 32'd0);
      chk(D, "rst_fwd_b", fw_b, 32'd0);
      chk(D, "rst_done", done, 32'd0);
      chk(D, "rst_perf", ret, 32'd0);
      chk(D, "rst_rf_we_passthru", we_wb, 32'd1);
      @(negedge clk);
      lsu_we = 1'b0;
      rst_n  = 1'b1;

      // back-to-back OTHER writes to x5
      for (int k = 1; k <= 3; k++) step(1'b1, mk(WB_INSTR_OTHER, 5'd5, 32'(k), 1'b1, 1'b0), 1'b0, 5'd5, 5'd0);
      step(1'b0, idle, 1'b0, 5'd5, 5'd0);
      step(1'b0, idle, 1'b0, 5'd5, 5'd0);

      // fill with loads, then retire and push in the same cycle
      for (int k = 0; k < D; k++) step(1'b1, mk(WB_INSTR_LOAD, 5'(7 + k), 32'h0, 1'b0, 1'b0), 1'b0, 5'd7, 5'd8);
      step(1'b0, idle, 1'b0, 5'd7, 5'd8);
      step(1'b1, mk(WB_INSTR_OTHER, 5'd9, 32'h99, 1'b1, 1'b0), 1'b1, 5'd7, 5'd9);
      step(1'b0, idle, 1'b0, 5'd8, 5'd9);
      drain();

      // forwarding priority behind a blocking store
      step(1'b1, mk(WB_INSTR_STORE, 5'd1, 32'h0, 1'b0, 1'b0), 1'b0, 5'd3, 5'd3);
      for (int k = 0; k < D - 1; k++) step(1'b1, mk(WB_INSTR_OTHER, 5'd3, 32'hA + 32'(k), 1'b1, 1'b0), 1'b0, 5'd0, 5'd3);
      step(1'b0, idle, 1'b0, 5'd3, 5'd3);
      step(1'b0, idle, 1'b0, 5'd0, 5'd0);
      drain();

      // store with error response
      step(1'b1, mk(WB_INSTR_STORE, 5'd2, 32'h0, 1'b0, 1'b1), 1'b0, 5'd2, 5'd0);
      step(1'b0, idle, 1'b1, 5'd2, 5'd0);
      drain();

      for (int n = 0; n < 300; n++) begin
        step($urandom_range(0, 9) < 7, rand_rec(), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end
      drain();

      // reset with two loads pending
      step(1'b1, mk(WB_INSTR_LOAD, 5'd4, 32'h0, 1'b0, 1'b0), 1'b0, 5'd4, 5'd0);
      step(1'b1, mk(WB_INSTR_LOAD, 5'd6, 32'h0, 1'b0, 1'b0), 1'b0, 5'd4, 5'd6);
      @(negedge clk);
      rst_n = 1'b0; en = 1'b0; lsu_valid = 1'b0; lsu_err = 1'b0; lsu_we = 1'b0;
      model_q.delete();
      exp_q.delete();
      #1;
      chk(D, "midrst_ready", ready, 32'd1);
      chk(D, "midrst_out_load", out_ld, 32'd0);
      @(negedge clk);
      #1;
      chk(D, "midrst_ready_next", ready, 32'd1);
      chk(D, "midrst_out_load_next", out_ld, 32'd0);
      chk(D, "midrst_hazard_a", hz_a, 32'd0);
      rst_n = 1'b1;
      for (int n = 0; n < 20; n++) begin
        step($urandom_range(0, 9) < 7, rand_rec(), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end
      drain();
      fin = 1'b1;
    end
  end

  initial begin
    for (int t = 0; t < 20000 && !(g_d[0].fin && g_d[1].fin); t++) @(negedge clk);
    if (!(g_d[0].fin && g_d[1].fin)) begin
      checks++;
      errors++;
      $display("FAIL timeout: got unfinished runs, expected both complete");
    end
    #4;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ibex_wb_queue.md
# ibex_wb_queue

Parametrised multi-entry writeback stage between ID/EX and the register file. Holds up to `Depth` in-flight instructions in program order, so ID/EX can issue further instructions while earlier loads/stores await LSU responses. Retires at most one instruction per cycle from the head, merges ID/EX results with LSU load data onto the single RF write port, and supplies per-operand hazard and forwarding information to ID/EX. `Depth = 1` is cycle-equivalent to the single-entry writeback stage.

## Interface
- `Depth`, 2: number of entries, ≥1; need not be a power of two.
- `ResetAll`, 1'b0: when set, the payload flops are also reset (to 0); otherwise only valid/pointer state is reset.
- `clk_i` input 1: clock.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `en_wb_i` input 1: ID/EX hands over an instruction. Legal only when `ready_wb_o` is 1.
- `instr_type_wb_i` input `ibex_pkg::wb_instr_type_e`: LOAD, STORE or OTHER.
- `pc_id_i` input 32: instruction PC.
- `instr_is_compressed_id_i` input 1: the instruction is compressed.
- `instr_perf_count_id_i` input 1: the instruction counts toward perf counters.
- `rf_waddr_id_i` / `rf_wdata_id_i` / `rf_we_id_i` input 5/32/1: ID/EX result.
- `rf_raddr_a_i`, `rf_raddr_b_i` input 5 each: ID operand addresses for hazard lookup.
- `rf_wdata_lsu_i` / `rf_we_lsu_i` input 32/1: LSU load write.
- `lsu_resp_valid_i`, `lsu_resp_err_i` input 1 each: in-order LSU response.
- `ready_wb_o` output 1: the queue can accept an instruction this cycle.
- `outstanding_load_wb_o`, `outstanding_store_wb_o` output 1 each: any valid entry is a load / store.
- `pc_wb_o` output 32: PC of the head entry.
- `rf_hazard_a_o`, `rf_hazard_b_o` output 1 each: the youngest valid entry writing the operand register is a LOAD. ID must stall.
- `rf_fwd_a_o`, `rf_fwd_b_o` output 1 each: the youngest matching entry has `rf_we` set and is not a LOAD.
- `rf_fwd_data_a_o`, `rf_fwd_data_b_o` output 32 each: `wdata` of that youngest matching entry.
- `rf_waddr_wb_o` / `rf_wdata_wb_o` / `rf_we_wb_o` output 5/32/1: RF write port.
- `perf_instr_ret_wb_o`, `perf_instr_ret_compressed_wb_o`, `instr_done_wb_o` output 1 each: retire events.

## Operation
- **Entry fields:** type, `we`, `waddr`, `wdata`, `pc`, `compressed`, `count`.
- **Storage:** circular buffer with `wr_ptr`, `rd_ptr` and `count`.
  - Pointers are `$clog2(Depth)` bits, minimum 1, and wrap explicitly from `Depth-1` to 0.
  - `count` is `$clog2(Depth+1)` bits.
- **Head completion:** `head_done = valid_head & (type_head == OTHER | lsu_resp_valid_i)`.
- **Push / pop:**
  - Push when `en_wb_i & ready_wb_o`.
  - Pop when `head_done`.
  - `count` changes by push − pop.
- **Ready:** `ready_wb_o = (count != Depth) | head_done`. A full queue accepts a push in the same cycle it retires.
- **RF write:**
  - Head's ID result is written when `valid_head & we_head`; `rf_waddr_wb_o = waddr_head`.
  - Otherwise LSU data is passed through: `rf_we_wb_o = rf_we_lsu_i`, data `rf_wdata_lsu_i`.
  - Both sources active together is illegal (asserted).
- **Retire outputs:**
  - `instr_done_wb_o = head_done`.
  - `perf_instr_ret_wb_o = head_done & count_head & ~(lsu_resp_valid_i & lsu_resp_err_i)`.
  - The compressed variant additionally ANDs `compressed_head`.
- **Hazard lookup:**
  - Scan all valid entries; the youngest match relative to `wr_ptr` wins.
  - `raddr == 0` never matches.
  - An entry popping this cycle still participates in the lookup.
- **LSU response with no LOAD/STORE at the head:** illegal (asserted).
- **Reset mid-operation:** all entries are invalidated immediately. Outstanding LSU responses are the LSU's responsibility.

## Timing
- An instruction pushed in cycle N is visible at the head no earlier than N+1.
- An OTHER entry at the head retires in the same cycle it reaches the head. Each entry occupies the queue for at least one cycle.
- LOAD/STORE entries retire in the cycle `lsu_resp_valid_i` is high.
- Throughput: one push and one pop per cycle.
- All outputs are combinational from registered state plus the LSU/raddr inputs; there is no combinational path from `en_wb_i` to any output.
- **Reset values** (with `ResetAll = 0`, `pc_wb_o` and forwarded data are don't-care; compare only under valid):

| Output(s) | Reset value |
|---|---|
| `count`, all valid bits | 0 |
| `ready_wb_o` | 1 |
| outstanding / hazard / fwd / done / perf outputs | 0 |
| `rf_we_wb_o` | `rf_we_lsu_i` |
| `pc_wb_o` | 0 with `ResetAll = 1` |

## Structure
- `wb_instr_type_e` stays in `ibex_pkg`.
- Add to `ibex_pkg`: `wb_entry_t`, a packed struct of the entry fields.
- One sub-module: `ibex_wb_hazard_lookup`, instantiated once per operand. It is a youngest-match priority search over the entry array.

## Test plan
1. **Depth = 2, back-to-back OTHER.**
   - Stimulus: push three OTHER instructions writing x5 = 1, 2, 3 in consecutive cycles.
   - Response: RF writes 1, 2, 3 in cycles N+1..N+3; `ready_wb_o` stays 1 throughout.
2. **Depth = 2, fill with loads.**
   - Stimulus: push LOAD x7 then LOAD x8, no response.
   - Response: `ready_wb_o` = 0 and `outstanding_load_wb_o` = 1; `rf_hazard_a_o` = 1 for `raddr_a` = 7.
   - Stimulus: a response arrives with `en_wb_i` asserted.
   - Response: `ready_wb_o` = 1 and the push is accepted that cycle; `count` stays 2.
3. **Forwarding priority.**
   - Stimulus: queue holds OTHER x3 = 0xA (older) and OTHER x3 = 0xB (younger); `raddr_b` = 3.
   - Response: `rf_fwd_b_o` = 1, `rf_fwd_data_b_o` = 0xB.
   - Stimulus: `raddr_b` = 0.
   - Response: no forward.
4. **LSU error.**
   - Stimulus: a STORE with count = 1 gets a response with error.
   - Response: `instr_done_wb_o` = 1, `perf_instr_ret_wb_o` = 0.
5. **Wrap-around at Depth = 3.**
   - Stimulus: 10 mixed push/pop cycles.
   - Response: retire order and PCs match push order; pointers wrap 2→0.
6. **Reset mid-operation.**
   - Stimulus: assert `rst_ni` low with two loads pending.
   - Response: next cycle `ready_wb_o` = 1 and `outstanding_load_wb_o` = 0.
